// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, widths, state encoding and rotation helper
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    // 1-based bit positions, bit 1 = MSB of the 64-bit key
    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // 1-based bit positions into the 56-bit C||D value
    localparam int PC2 [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Right-rotation applied when leaving decryption round r; entry 0 is unused
    localparam int unsigned ROT_R [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [0:HALF_W-1] rotr(input logic [0:HALF_W-1] h, input int unsigned s);
        return (s == 2) ? {h[26:27], h[0:25]} : {h[27], h[0:26]};
    endfunction

endpackage

// File: rtl/des_key_schedule_decrypt_if.sv
// des_key_schedule_decrypt_if: start/advance request and subkey result bundle
interface des_key_schedule_decrypt_if;
    logic        start_strobe_din;
    logic [0:63] key_din;
    logic        advance_din;
    logic [0:47] round_key_dout;
    logic        round_key_valid_dout;
    logic [3:0]  round_number_dout;
    logic        busy_dout;
    logic        done_dout;

    modport master (
        output start_strobe_din, key_din, advance_din,
        input  round_key_dout, round_key_valid_dout, round_number_dout, busy_dout, done_dout
    );

    modport slave (
        input  start_strobe_din, key_din, advance_din,
        output round_key_dout, round_key_valid_dout, round_number_dout, busy_dout, done_dout
    );
endinterface

// File: rtl/des_key_pc2.sv
// des_key_pc2: DES permuted choice 2, compressing C||D (56 bits) into a 48-bit subkey
module des_key_pc2
    import des_pkg::*;
(
    input  logic [0:CD_W-1]     cd_i,
    output logic [0:SUBKEY_W-1] key_o
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
        assign key_o[i] = cd_i[PC2[i] - 1];
    end

endmodule

// File: rtl/des_key_schedule_decrypt.sv
// des_key_schedule_decrypt: emits DES subkeys K16..K1 one per accepted advance
module des_key_schedule_decrypt
    import des_pkg::*;
(
    input  logic clk,
    input  logic reset,
    des_key_schedule_decrypt_if.slave bus
);

    state_e              state_q;
    logic [0:HALF_W-1]   c_q, d_q, c_d, d_d;
    logic [4:0]          round_q;
    logic                done_q;
    logic [0:CD_W-1]     pc1_w;
    logic [0:SUBKEY_W-1] pc2_w;
    logic                parity_unused_w;

    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign pc1_w[i] = bus.key_din[PC1[i] - 1];
    end

    assign parity_unused_w = ^{bus.key_din[7], bus.key_din[15], bus.key_din[23], bus.key_din[31],
                               bus.key_din[39], bus.key_din[47], bus.key_din[55], bus.key_din[63]};

    assign c_d = rotr(c_q, ROT_R[round_q[3:0]]);
    assign d_d = rotr(d_q, ROT_R[round_q[3:0]]);

    des_key_pc2 u_pc2 (
        .cd_i  ({c_q, d_q}),
        .key_o (pc2_w)
    );

    assign bus.round_key_dout       = (state_q == ST_ACTIVE) ? pc2_w : '0;
    assign bus.round_key_valid_dout = (state_q == ST_ACTIVE);
    assign bus.busy_dout            = (state_q == ST_ACTIVE);
    assign bus.round_number_dout    = round_q[3:0];
    assign bus.done_dout            = done_q;

    // Schedule FSM: latch PC-1 on start, rotate right per accepted round, pulse done after round 16
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (bus.start_strobe_din) begin
                    {c_q, d_q} <= pc1_w;
                    round_q    <= 5'd1;
                    state_q    <= ST_ACTIVE;
                end
            end else if (bus.advance_din) begin
                if (round_q == 5'd16) begin
                    state_q <= ST_IDLE;
                    round_q <= '0;
                    done_q  <= 1'b1;
                end else begin
                    c_q     <= c_d;
                    d_q     <= d_d;
                    round_q <= round_q + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_key_schedule_decrypt.sv
// tb_des_key_schedule_decrypt: scoreboard bench against a reference DES encrypt-order key model
module tb_des_key_schedule_decrypt;

    logic clk;
    logic reset;
    des_key_schedule_decrypt_if bus ();

    des_key_schedule_decrypt dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_STD  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_PAR  = 64'h0101010101010101;
    localparam logic [63:0] KEY_ONES = 64'hFFFFFFFFFFFFFFFF;

    typedef struct {
        logic [3:0]  rnd;
        logic [47:0] key;
    } beat_t;

    beat_t sb [$];
    int n_chk = 0;
    int n_fail = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic [63:0] rk;

    // Standard encryption subkey Kn: PC-1, cumulative left shift, PC-2
    function automatic logic [47:0] ref_sub(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        int sh = 0;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < n; i++) sh += SHIFTS[i];
        for (int j = 0; j < sh; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
        return k;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Monitor: every accepted subkey is popped from the scoreboard and compared
    always @(negedge clk) begin : mon
        beat_t e;
        if (bus.done_dout) done_seen++;
        if (bus.round_key_valid_dout && bus.advance_din) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("beat_round", 64'(bus.round_number_dout), 64'(e.rnd));
                chk("beat_key", 64'(bus.round_key_dout), 64'(e.key));
            end
        end
    end

    // mode: 0 advance always, 1 stall 5 at ev, 2 ignored restart at ev, 3 reset at ev, 4 random advance
    task automatic run(input logic [63:0] key, input int mode, input int ev);
        int r = 1;
        int cyc = 0;
        bit stalled = 0;
        bus.start_strobe_din = 1'b1;
        bus.key_din = key;
        bus.advance_din = 1'b0;
        for (int k = 1; k <= 16; k++) sb.push_back('{rnd: 4'(k), key: ref_sub(key, 17 - k)});
        cycle();
        cyc = 1;
        bus.start_strobe_din = 1'b0;
        chk("first_valid", 64'(bus.round_key_valid_dout), 64'd1);
        chk("first_round", 64'(bus.round_number_dout), 64'd1);
        chk("first_busy", 64'(bus.busy_dout), 64'd1);
        chk("first_done_low", 64'(bus.done_dout), 64'd0);
        chk("first_key", 64'(bus.round_key_dout), 64'(ref_sub(key, 16)));
        while (r <= 16 && cyc < 300) begin
            if (mode == 3 && r == ev) begin
                reset = 1'b1;
                bus.start_strobe_din = 1'b1;
                bus.advance_din = 1'b1;
                bus.key_din = KEY_ONES;
                cycle();
                reset = 1'b0;
                bus.start_strobe_din = 1'b0;
                bus.advance_din = 1'b0;
                bus.key_din = key;
                chk("rst_valid", 64'(bus.round_key_valid_dout), 64'd0);
                chk("rst_busy", 64'(bus.busy_dout), 64'd0);
                chk("rst_round", 64'(bus.round_number_dout), 64'd0);
                chk("rst_key", 64'(bus.round_key_dout), 64'd0);
                chk("rst_done", 64'(bus.done_dout), 64'd0);
                sb.delete();
                cycle();
                chk("rst_no_done", 64'(bus.done_dout), 64'd0);
                return;
            end
            if (mode == 1 && r == ev && !stalled) begin
                stalled = 1;
                bus.advance_din = 1'b0;
                repeat (5) begin
                    cycle();
                    cyc++;
                    chk("hold_key", 64'(bus.round_key_dout), 64'(ref_sub(key, 17 - r)));
                    chk("hold_round", 64'(bus.round_number_dout), 64'(4'(r)));
                    chk("hold_valid", 64'(bus.round_key_valid_dout), 64'd1);
                end
            end
            bus.advance_din = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2 && r == ev) begin
                bus.start_strobe_din = 1'b1;
                bus.key_din = KEY_ONES;
            end
            cycle();
            cyc++;
            bus.start_strobe_din = 1'b0;
            bus.key_din = key;
            if (bus.advance_din) r++;
        end
        if (r <= 16) chk("schedule_timeout", 64'(r), 64'd17);
        chk("end_done", 64'(bus.done_dout), 64'd1);
        chk("end_valid", 64'(bus.round_key_valid_dout), 64'd0);
        chk("end_busy", 64'(bus.busy_dout), 64'd0);
        chk("end_round", 64'(bus.round_number_dout), 64'd0);
        chk("end_key", 64'(bus.round_key_dout), 64'd0);
        if (mode == 0) chk("done_latency", 64'(cyc), 64'd17);
        exp_done++;
    endtask

    initial begin
        reset = 1'b1;
        bus.start_strobe_din = 1'b0;
        bus.key_din = '0;
        bus.advance_din = 1'b0;
        repeat (2) cycle();
        chk("reset_valid", 64'(bus.round_key_valid_dout), 64'd0);
        chk("reset_busy", 64'(bus.busy_dout), 64'd0);
        chk("reset_round", 64'(bus.round_number_dout), 64'd0);
        chk("reset_done", 64'(bus.done_dout), 64'd0);
        chk("reset_key", 64'(bus.round_key_dout), 64'd0);
        reset = 1'b0;
        bus.advance_din = 1'b1;
        repeat (3) cycle();
        chk("idle_adv_valid", 64'(bus.round_key_valid_dout), 64'd0);
        chk("idle_adv_round", 64'(bus.round_number_dout), 64'd0);
        chk("idle_adv_key", 64'(bus.round_key_dout), 64'd0);
        chk("model_k16", 64'(ref_sub(KEY_STD, 16)), 64'hCB3D8B0E17F5);
        chk("model_k1", 64'(ref_sub(KEY_STD, 1)), 64'h1B02EFFC7072);
        run(KEY_STD, 0, 0);
        rk = {$urandom, $urandom};
        run(rk, 0, 0);
        bus.advance_din = 1'b0;
        cycle();
        chk("done_one_cycle", 64'(bus.done_dout), 64'd0);
        run(KEY_PAR, 0, 0);
        bus.advance_din = 1'b0;
        cycle();
        run(KEY_STD, 1, 3);
        run(KEY_STD, 2, 8);
        run(KEY_STD, 3, 10);
        run(KEY_STD, 0, 0);
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom};
            run(rk, 4, 0);
            if ($urandom_range(0, 1) == 1) begin
                bus.advance_din = 1'b0;
                cycle();
            end
        end
        bus.advance_din = 1'b0;
        repeat (3) cycle();
        chk("done_count", 64'(done_seen), 64'(exp_done));
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_schedule_decrypt.md
DES_KEY_SCHEDULE_DECRYPT -- requirements
Module: des_key_schedule_decrypt

Interface
REQ-001 Parameters: none; all widths fixed by the DES standard.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_strobe_din  input  1  one-cycle request to begin a new schedule using key_din.
REQ-005 key_din  input  [0:63]  64-bit DES key, bit 0 = MSB; parity bits 7,15,...,63 ignored.
REQ-006 advance_din  input  1  consumer accepts current subkey and requests the next.
REQ-007 round_key_dout  output  [0:47]  current decryption subkey (K16 first, K1 last).
REQ-008 round_key_valid_dout  output  1  round_key_dout and round_number_dout are valid.
REQ-009 round_number_dout  output  [3:0]  decryption round index 1..16; 0 when idle.
REQ-010 busy_dout  output  1  high from the cycle after an accepted start until the schedule ends.
REQ-011 done_dout  output  1  one-cycle pulse in the cycle after round 16 is accepted.

Function
REQ-012 The block SHALL have two states: IDLE and ACTIVE.
REQ-013 In IDLE, start_strobe_din=1 SHALL latch C,D = PC-1(key_din) (28+28 bits). Next cycle: state ACTIVE, round 1, valid=1, busy=1.
REQ-014 Start-to-first-valid latency SHALL be exactly 1 cycle.
REQ-015 round_key_dout SHALL be PC-2(C,D) combinationally from the registered C,D; round 1 outputs PC-2(C0,D0) = K16 with no rotation.
REQ-016 In ACTIVE with advance_din=1 and round r<16, C and D SHALL each rotate right by R[r] and the round SHALL become r+1 on the next edge. R[1..15] = 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 Without advance_din, C, D, round and the outputs SHALL hold (back-pressure; no timeout).
REQ-018 In ACTIVE with advance_din=1 at round 16: next cycle state IDLE, valid=0, busy=0, round=0, done_dout=1 for exactly one cycle.
REQ-019 start_strobe_din in ACTIVE SHALL be ignored; the running schedule is unaffected.
REQ-020 start_strobe_din in the same cycle done_dout is high SHALL be accepted, since the state is IDLE.
REQ-021 advance_din in IDLE SHALL be ignored.
REQ-022 In IDLE, round_key_dout SHALL be all zeros.
REQ-023 Cumulative right rotation after round 16 SHALL be 27 per half, with no wrap-around ambiguity; rotation is modulo 28 within each half.

Reset
REQ-024 reset=1 SHALL force on the next edge: state IDLE, C=D=0, round=0, valid=0, busy=0, done=0, round_key_dout=0.
REQ-025 reset SHALL take priority over start_strobe_din and advance_din in the same cycle.
REQ-026 reset during ACTIVE SHALL abort the schedule with no done pulse.

Structure
REQ-027 The shared package des_pkg SHALL hold the PC-1 and PC-2 tables, the decryption rotation table R, the state encoding, and the width constants (64, 56, 28, 48).
REQ-028 One sub-module SHALL be used: des_key_pc2 (combinational 56->48 permutation), reusable by the encrypt-side scheduler.
REQ-029 Registers SHALL be limited to C, D, the round counter, the state, and done. Outputs other than round_key_dout SHALL be registered.

Verification
REQ-030 key_din=133457799BBCDFF1, start, advance every cycle -> round 1 key CB3D8B0E17F5, round 16 key 1B02EFFC7072, done 17 cycles after start.
REQ-031 key_din=0101010101010101 (parity-only bits) -> all 16 subkeys 000000000000; done pulses once.
REQ-032 Same key as REQ-030, advance withheld 5 cycles at round 3 -> outputs stable for those 5 cycles, then the sequence resumes unchanged.
REQ-033 start re-asserted at round 8 with key_din=FFFFFFFFFFFFFFFF -> ignored; remaining subkeys match REQ-030.
REQ-034 reset asserted at round 10 -> next cycle valid=0, busy=0, round=0, no done; a new start then produces CB3D8B0E17F5 first.
REQ-035 start in the done cycle -> valid with round 1 on the following cycle (back-to-back schedules, no idle gap).
